// File: rtl/turbo_pkg.sv
// Shared constants, state encoding and modular adder for the LTE QPP
// interleaver/deinterleaver pair.
package turbo_pkg;

    localparam int IDX_W  = 13;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 10;

    localparam int K0   = 1056;
    localparam int F1_0 = 17;
    localparam int F2_0 = 66;
    localparam int K1   = 6144;
    localparam int F1_1 = 263;
    localparam int F2_1 = 480;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef logic [IDX_W-1:0] idx_t;

    // Both operands are already reduced below k, so one conditional subtract suffices.
    function automatic idx_t mod_add(input idx_t a, input idx_t b, input idx_t k);
        logic [IDX_W:0] sum;
        logic [IDX_W:0] diff;
        sum  = {1'b0, a} + {1'b0, b};
        diff = sum - {1'b0, k};
        return (sum >= {1'b0, k}) ? diff[IDX_W-1:0] : sum[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/qpp_addr_gen.sv
// Incremental QPP address generator: produces pi(8n..8n+7) for the current
// byte and steps its p/g state by eight bits on each advance.
module qpp_addr_gen
    import turbo_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [IDX_W-1:0]           g_init,
    input  logic                       advance,
    input  logic [IDX_W-1:0]           k,
    input  logic [IDX_W-1:0]           two_f2,
    output logic [7:0][IDX_W-1:0]      addr
);

    idx_t p_q, p_d;
    idx_t g_q, g_d;
    idx_t p_chain, g_chain;

    always_comb begin
        p_chain = p_q;
        g_chain = g_q;
        addr    = '0;
        for (int b = 0; b < 8; b++) begin
            addr[b] = p_chain;
            p_chain = mod_add(p_chain, g_chain, k);
            g_chain = mod_add(g_chain, two_f2, k);
        end

        p_d = p_q;
        g_d = g_q;
        if (start) begin
            p_d = '0;
            g_d = g_init;
        end else if (advance) begin
            p_d = p_chain;
            g_d = g_chain;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_q <= '0;
            g_q <= '0;
        end else begin
            p_q <= p_d;
            g_q <= g_d;
        end
    end

endmodule

// File: rtl/turbo_deinterleaver.sv
// LTE QPP turbo deinterleaver: scatters each incoming byte's bits to pi(j)
// in a K1-bit store, then streams the store out in natural byte order.
module turbo_deinterleaver
    import turbo_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              vld_in,
    input  logic              cbs,
    input  logic              data_vld,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rdy_out,
    output logic              rdy_in,
    output logic              vld_out,
    output logic [DATA_W-1:0] data_out
);

    state_t             state_q, state_d;
    logic               cbs_q, cbs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [K1-1:0]      mem_q, mem_d;

    logic               start, advance;
    logic [IDX_W-1:0]   k_sel, two_f2_sel, g_init;
    logic [CNT_W-1:0]   last_byte;
    logic [7:0][IDX_W-1:0] addr;

    assign k_sel      = cbs_q ? IDX_W'(K1) : IDX_W'(K0);
    assign two_f2_sel = cbs_q ? IDX_W'(2 * F2_1) : IDX_W'(2 * F2_0);
    assign last_byte  = cbs_q ? CNT_W'(K1 / 8 - 1) : CNT_W'(K0 / 8 - 1);
    // Seed uses the live cbs because it is captured on the same edge as cbs_q.
    assign g_init     = cbs ? IDX_W'(F1_1 + F2_1) : IDX_W'(F1_0 + F2_0);

    qpp_addr_gen u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .g_init  (g_init),
        .advance (advance),
        .k       (k_sel),
        .two_f2  (two_f2_sel),
        .addr    (addr)
    );

    always_comb begin
        state_d = state_q;
        cbs_d   = cbs_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (vld_in) begin
                    cbs_d   = cbs;
                    cnt_d   = '0;
                    start   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (data_vld) begin
                    advance = 1'b1;
                    if (cnt_q == last_byte) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (rdy_out) begin
                    if (cnt_q == last_byte) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (state_q == LOAD && data_vld) begin
            for (int b = 0; b < DATA_W; b++) begin
                mem_d[addr[b]] = data_in[b];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cbs_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cbs_q   <= cbs_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every bit is rewritten each block, so the store carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdy_in   = (state_q == IDLE);
    assign vld_out  = (state_q == DRAIN);
    assign data_out = vld_out ? mem_q[{cnt_q, 3'b000} +: DATA_W] : '0;

endmodule

// File: tb/tb_turbo_deinterleaver.sv
// Directed bench for turbo_deinterleaver: single-bit vectors, modelled
// loopback, stalls and mid-block resets.
module tb_turbo_deinterleaver;

    logic       clk = 1'b0;
    logic       reset;
    logic       vld_in;
    logic       cbs;
    logic       data_vld;
    logic [7:0] data_in;
    logic       rdy_out;
    logic       rdy_in;
    logic       vld_out;
    logic [7:0] data_out;

    always #5 clk = ~clk;

    turbo_deinterleaver dut (
        .clk      (clk),
        .reset    (reset),
        .vld_in   (vld_in),
        .cbs      (cbs),
        .data_vld (data_vld),
        .data_in  (data_in),
        .rdy_out  (rdy_out),
        .rdy_in   (rdy_in),
        .vld_out  (vld_out),
        .data_out (data_out)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] in_blk  [768];
    logic [7:0] got_blk [768];
    logic [7:0] ref_blk [768];
    logic [7:0] orig    [768];

    typedef struct {
        bit         cbs;
        int         in_idx;
        logic [7:0] in_val;
        int         out_idx;
        logic [7:0] out_val;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic int pi_f(input int j, input bit c);
        longint k, f1, f2;
        k  = c ? 6144 : 1056;
        f1 = c ? 263 : 17;
        f2 = c ? 480 : 66;
        return int'((f1 * j + f2 * longint'(j) * j) % k);
    endfunction

    function automatic int nbytes_f(input bit c);
        return c ? 768 : 132;
    endfunction

    // Drives one block; abort_load/abort_drain >= 0 pulse reset at that byte.
    task automatic run_block(input bit c, input int vld_stall_pct, input int rdy_stall_pct,
                             input int abort_load, input int abort_drain);
        int         n, sent, got, guard, unstable, gaps;
        bit         prev_stall;
        logic [7:0] prev_data;
        n = nbytes_f(c);
        check("rdy_in_before_start", 32'(rdy_in), 32'd1);
        vld_in = 1'b1;
        cbs    = c;
        @(negedge clk);
        vld_in = 1'b0;
        cbs    = ~c;
        sent   = 0;
        guard  = 0;
        while (sent < n && guard < 20000) begin
            if (sent == abort_load) begin
                data_vld = 1'b0;
                reset    = 1'b0;
                #1;
                check("abort_load_vld_out", 32'(vld_out), 32'd0);
                check("abort_load_rdy_in", 32'(rdy_in), 32'd1);
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            data_vld = (vld_stall_pct > 0 && $urandom_range(99) < vld_stall_pct) ? 1'b0 : 1'b1;
            data_in  = data_vld ? in_blk[sent] : 8'($urandom);
            if (data_vld) sent++;
            @(negedge clk);
            guard++;
        end
        data_vld = 1'b0;
        check("drain_latency_vld_out", 32'(vld_out), 32'd1);
        got        = 0;
        guard      = 0;
        unstable   = 0;
        gaps       = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (got < n && guard < 20000) begin
            if (got == abort_drain) begin
                reset = 1'b0;
                #1;
                check("abort_drain_vld_out", 32'(vld_out), 32'd0);
                check("abort_drain_rdy_in", 32'(rdy_in), 32'd1);
                check("abort_drain_data_out", 32'(data_out), 32'd0);
                @(negedge clk);
                reset   = 1'b1;
                rdy_out = 1'b1;
                return;
            end
            rdy_out = (rdy_stall_pct > 0 && $urandom_range(99) < rdy_stall_pct) ? 1'b0 : 1'b1;
            if (prev_stall && data_out !== prev_data) unstable++;
            if (!vld_out) gaps++;
            if (vld_out && rdy_out) begin
                got_blk[got] = data_out;
                got++;
            end
            prev_stall = vld_out && !rdy_out;
            prev_data  = data_out;
            @(negedge clk);
            guard++;
        end
        rdy_out = 1'b1;
        check("drain_byte_count", 32'(got), 32'(n));
        check("drain_stable_while_stalled", 32'(unstable), 32'd0);
        check("drain_vld_gaps", 32'(gaps), 32'd0);
        check("end_vld_out", 32'(vld_out), 32'd0);
        check("end_rdy_in", 32'(rdy_in), 32'd1);
    endtask

    task automatic make_random_orig(input bit c);
        for (int i = 0; i < 768; i++) orig[i] = (i < nbytes_f(c)) ? 8'($urandom) : 8'h00;
    endtask

    // Interleaver model: stream bit j carries original bit pi(j).
    task automatic interleave_orig(input bit c);
        int p;
        for (int i = 0; i < 768; i++) in_blk[i] = 8'h00;
        for (int j = 0; j < 8 * nbytes_f(c); j++) begin
            p = pi_f(j, c);
            in_blk[j / 8][j % 8] = orig[p / 8][p % 8];
        end
    endtask

    function automatic int diff_vs_orig(input bit c);
        int d = 0;
        for (int i = 0; i < nbytes_f(c); i++) if (got_blk[i] !== orig[i]) d++;
        return d;
    endfunction

    initial begin
        int others;
        int d;
        reset    = 1'b0;
        vld_in   = 1'b0;
        cbs      = 1'b0;
        data_vld = 1'b0;
        data_in  = '0;
        rdy_out  = 1'b1;

        vecs[0] = '{cbs: 1'b0, in_idx: 0, in_val: 8'h02, out_idx: 10, out_val: 8'h08};
        vecs[1] = '{cbs: 1'b0, in_idx: 0, in_val: 8'h08, out_idx: 80, out_val: 8'h20};
        vecs[2] = '{cbs: 1'b1, in_idx: 0, in_val: 8'h02, out_idx: 92, out_val: 8'h80};
        vecs[3] = '{cbs: 1'b0, in_idx: 0, in_val: 8'h01, out_idx: 0,  out_val: 8'h01};
        vecs[4] = '{cbs: 1'b0, in_idx: 1, in_val: 8'h01, out_idx: 17, out_val: 8'h01};

        repeat (3) @(negedge clk);
        check("reset_rdy_in", 32'(rdy_in), 32'd1);
        check("reset_vld_out", 32'(vld_out), 32'd0);
        check("reset_data_out", 32'(data_out), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 768; i++) in_blk[i] = 8'h00;
            in_blk[vecs[v].in_idx] = vecs[v].in_val;
            run_block(vecs[v].cbs, 0, 0, -1, -1);
            check($sformatf("vec%0d_byte%0d", v, vecs[v].out_idx),
                  32'(got_blk[vecs[v].out_idx]), 32'(vecs[v].out_val));
            others = 0;
            for (int i = 0; i < nbytes_f(vecs[v].cbs); i++)
                if (i != vecs[v].out_idx && got_blk[i] !== 8'h00) others++;
            check($sformatf("vec%0d_other_bytes_nonzero", v), 32'(others), 32'd0);
        end

        // Back-to-back loopback with alternating block sizes.
        for (int r = 0; r < 4; r++) begin
            make_random_orig(r[0]);
            interleave_orig(r[0]);
            run_block(r[0], 0, 0, -1, -1);
            d = diff_vs_orig(r[0]);
            check($sformatf("loopback%0d_cbs%0d_bad_bytes", r, r[0]), 32'(d), 32'd0);
        end

        // Stall-free reference, then the same block under random stalls.
        make_random_orig(1'b1);
        interleave_orig(1'b1);
        run_block(1'b1, 0, 0, -1, -1);
        for (int i = 0; i < 768; i++) ref_blk[i] = got_blk[i];
        run_block(1'b1, 30, 30, -1, -1);
        d = 0;
        for (int i = 0; i < 768; i++) if (got_blk[i] !== ref_blk[i]) d++;
        check("stall_vs_nostall_bad_bytes", 32'(d), 32'd0);
        check("stall_vs_orig_bad_bytes", 32'(diff_vs_orig(1'b1)), 32'd0);

        // Resets mid-LOAD and mid-DRAIN, each followed by a full block.
        make_random_orig(1'b0);
        interleave_orig(1'b0);
        run_block(1'b0, 0, 0, 50, -1);
        run_block(1'b0, 0, 0, -1, -1);
        check("after_load_reset_bad_bytes", 32'(diff_vs_orig(1'b0)), 32'd0);
        make_random_orig(1'b1);
        interleave_orig(1'b1);
        run_block(1'b1, 0, 0, -1, 20);
        run_block(1'b1, 0, 0, -1, -1);
        check("after_drain_reset_bad_bytes", 32'(diff_vs_orig(1'b1)), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
